// File: rtl/seg_dma_writer_if.sv
// rtl/seg_dma_writer_if.sv - DMA write port bundle between the segment writer and memory
interface seg_dma_writer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic                  dma_wr_full;
  logic                  dma_wr_en;
  logic [ADDR_WIDTH-1:0] dma_wr_addr;
  logic [DATA_WIDTH-1:0] dma_wr_data;
  logic                  dma_wr_resp;

  // Writer side: issues requests, observes backpressure and completions
  modport master (
    input  dma_wr_full,
    input  dma_wr_resp,
    output dma_wr_en,
    output dma_wr_addr,
    output dma_wr_data
  );

  // Memory side: accepts requests, returns completions
  modport slave (
    output dma_wr_full,
    output dma_wr_resp,
    input  dma_wr_en,
    input  dma_wr_addr,
    input  dma_wr_data
  );
endinterface

// File: rtl/seg_dma_writer.sv
// rtl/seg_dma_writer.sv - writes a self-describing pattern into four memory segments and counts completions
module seg_dma_writer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int SEG_LINES  = 16,
  parameter int LINE_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
  input  logic                  go,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cv_value,
  seg_dma_writer_if.master      dma
);

  localparam int REPL  = DATA_WIDTH / ADDR_WIDTH;
  localparam int TOTAL = 4 * SEG_LINES;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] seg_base [4];
  logic [1:0]            seg;
  logic [31:0]           line;
  logic [31:0]           issued;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // Address of the next line to issue; wraps naturally at 2^ADDR_WIDTH
  always_comb begin
    cur_addr = seg_base[seg] + ADDR_WIDTH'(line) * ADDR_WIDTH'(LINE_BYTES);
  end

  // Control FSM with registered request outputs and completion counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      done            <= 1'b0;
      cv_value        <= '0;
      seg             <= '0;
      line            <= '0;
      issued          <= '0;
      seg_base[0]     <= '0;
      seg_base[1]     <= '0;
      seg_base[2]     <= '0;
      seg_base[3]     <= '0;
      dma.dma_wr_en   <= 1'b0;
      dma.dma_wr_addr <= '0;
      dma.dma_wr_data <= '0;
    end else begin
      dma.dma_wr_en <= 1'b0;

      // Completions count everywhere but IDLE; a go below overrides with a clear
      if (dma.dma_wr_resp && state != S_IDLE) begin
        cv_value <= cv_value + 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            seg_base[0] <= wr_addr_s0;
            seg_base[1] <= wr_addr_s1;
            seg_base[2] <= wr_addr_s2;
            seg_base[3] <= wr_addr_s3;
            done        <= 1'b0;
            cv_value    <= '0;
            seg         <= '0;
            line        <= '0;
            issued      <= '0;
            state       <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (!dma.dma_wr_full) begin
            dma.dma_wr_en   <= 1'b1;
            dma.dma_wr_addr <= cur_addr;
            dma.dma_wr_data <= {REPL{cur_addr}};
            issued          <= issued + 1'b1;
            if (line == 32'(SEG_LINES - 1)) begin
              line <= '0;
              seg  <= seg + 1'b1;
            end else begin
              line <= line + 1'b1;
            end
            if (issued == 32'(TOTAL - 1)) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (cv_value == ADDR_WIDTH'(TOTAL)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_dma_writer.sv
// tb/tb_seg_dma_writer.sv - self-checking bench for seg_dma_writer
module tb_seg_dma_writer;

  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int SL_A = 16;
  localparam int SL_B = 4;
  localparam int LB   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wa0, wa1, wa2, wa3;
  logic          go, go_a, go_b;
  logic          done_a, done_b;
  logic [AW-1:0] cv_a, cv_b;

  seg_dma_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  seg_dma_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  seg_dma_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_LINES(SL_A), .LINE_BYTES(LB)) dut_a (
    .clk(clk), .rst(rst),
    .wr_addr_s0(wa0), .wr_addr_s1(wa1), .wr_addr_s2(wa2), .wr_addr_s3(wa3),
    .go(go_a), .done(done_a), .cv_value(cv_a), .dma(ifa)
  );

  seg_dma_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_LINES(SL_B), .LINE_BYTES(LB)) dut_b (
    .clk(clk), .rst(rst),
    .wr_addr_s0(wa0), .wr_addr_s1(wa1), .wr_addr_s2(wa2), .wr_addr_s3(wa3),
    .go(go_b), .done(done_b), .cv_value(cv_b), .dma(ifb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          run;
    int          idx;
    logic [63:0] addr;
  } vec_t;

  vec_t tab [12];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            sel, mode, delay, cyc;
  int            data_bad, stall_bad, hold_bad, resp_sent, first_done_resp;
  int            burst_left, first_cap_cyc, last_cap_cyc;
  bit            burst_done, done_seen, inject_resp;
  logic [63:0]   base [4];
  logic [63:0]   cap_q [$];
  int            due_q [$];
  logic          s_en, s_done;
  logic [63:0]   s_addr, s_cv;
  logic [DW-1:0] s_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference address of the k-th request of a run: segment-major, line-minor
  function automatic logic [63:0] ref_addr(input int k, input int sl);
    logic [63:0] off;
    off = 64'(k % sl) * 64'(LB);
    return base[k / sl] + off;
  endfunction

  // One clock: drive slave-side inputs, let the edge pass, sample on the falling edge
  task automatic step();
    logic f, r;
    f = 1'b0;
    if (mode == 1) begin
      if (cap_q.size() >= 30 && !burst_done) begin
        burst_left = 20;
        burst_done = 1'b1;
      end
      if (burst_left > 0) begin
        f = 1'b1;
        burst_left--;
      end else begin
        f = cyc[0];
      end
    end else if (mode == 2) begin
      f = ($urandom_range(0, 2) == 0);
    end
    r = inject_resp;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      r = 1'b1;
      void'(due_q.pop_front());
    end
    if (r) resp_sent++;
    ifa.dma_wr_full = (sel == 0) ? f : 1'b0;
    ifb.dma_wr_full = (sel == 1) ? f : 1'b0;
    ifa.dma_wr_resp = (sel == 0) ? r : 1'b0;
    ifb.dma_wr_resp = (sel == 1) ? r : 1'b0;
    go_a = go && (sel == 0);
    go_b = go && (sel == 1);
    @(negedge clk);
    s_en   = (sel == 0) ? ifa.dma_wr_en   : ifb.dma_wr_en;
    s_addr = (sel == 0) ? ifa.dma_wr_addr : ifb.dma_wr_addr;
    s_data = (sel == 0) ? ifa.dma_wr_data : ifb.dma_wr_data;
    s_done = (sel == 0) ? done_a : done_b;
    s_cv   = (sel == 0) ? cv_a   : cv_b;
    if (s_en) begin
      logic [63:0] a;
      a = s_addr;
      if (f) stall_bad++;
      if (s_data !== {8{a}}) data_bad++;
      if (cap_q.size() == 0) first_cap_cyc = cyc;
      last_cap_cyc = cyc;
      cap_q.push_back(a);
      due_q.push_back(cyc + delay);
    end else if (cap_q.size() > 0 && s_addr !== cap_q[$]) begin
      hold_bad++;
    end
    if (s_done && !done_seen) begin
      done_seen       = 1'b1;
      first_done_resp = resp_sent;
    end
    cyc++;
  endtask

  task automatic prep(input int s, input int m, input int d);
    sel = s; mode = m; delay = d;
    cap_q.delete(); due_q.delete();
    data_bad = 0; stall_bad = 0; hold_bad = 0; resp_sent = 0;
    first_done_resp = -1; burst_left = 0; burst_done = 1'b0; done_seen = 1'b0;
    first_cap_cyc = 0; last_cap_cyc = 0;
    wa0 = base[0]; wa1 = base[1]; wa2 = base[2]; wa3 = base[3];
  endtask

  task automatic finish_run(input string tag, input int sl);
    int n;
    bit mid;
    n = 0;
    mid = 1'b0;
    while (!done_seen && n < 3000) begin
      step();
      go = 1'b0;
      n++;
    end
    if (!done_seen) chk({tag, "_timeout"}, 0, 1);
    repeat (3) step();
    chk({tag, "_req_count"}, cap_q.size(), 4 * sl);
    chk({tag, "_done"}, s_done, 1);
    chk({tag, "_cv"}, s_cv, 4 * sl);
    chk({tag, "_data"}, data_bad, 0);
    chk({tag, "_en_while_full"}, stall_bad, 0);
    chk({tag, "_addr_hold"}, hold_bad, 0);
    chk({tag, "_done_after_last_resp"}, first_done_resp, 4 * sl);
    for (int k = 0; k < 4 * sl && k < cap_q.size(); k++) begin
      chk({tag, "_addr"}, cap_q[k], ref_addr(k, sl));
    end
    if (mode == 0) chk({tag, "_back_to_back"}, last_cap_cyc - first_cap_cyc, 4 * sl - 1);
  endtask

  task automatic run(input string tag, input int s, input int sl, input int m, input int d, input bit go_mid);
    int n;
    prep(s, m, d);
    go = 1'b1;
    step();
    go = 1'b0;
    n = 0;
    if (go_mid) begin
      while (cap_q.size() < 20 && n < 500) begin
        step();
        n++;
      end
      wa0 = ~64'h0; wa1 = ~64'h0; wa2 = ~64'h0; wa3 = ~64'h0;
      go = 1'b1;
      step();
      go = 1'b0;
    end
    finish_run(tag, sl);
  endtask

  task automatic check_tab(input int r);
    for (int i = 0; i < 12; i++) begin
      if (tab[i].run == r) begin
        if (tab[i].idx < cap_q.size()) chk("table_addr", cap_q[tab[i].idx], tab[i].addr);
        else chk("table_missing", cap_q.size(), tab[i].idx + 1);
      end
    end
  endtask

  initial begin
    tab[0]  = '{0, 0,  64'h1000};
    tab[1]  = '{0, 1,  64'h1040};
    tab[2]  = '{0, 15, 64'h13C0};
    tab[3]  = '{0, 16, 64'h2000};
    tab[4]  = '{0, 48, 64'h4000};
    tab[5]  = '{0, 63, 64'h43C0};
    tab[6]  = '{1, 0,  64'h0100};
    tab[7]  = '{1, 4,  64'h0200};
    tab[8]  = '{1, 12, 64'hFFFF_FFFF_FFFF_FF80};
    tab[9]  = '{1, 13, 64'hFFFF_FFFF_FFFF_FFC0};
    tab[10] = '{1, 14, 64'h0000_0000_0000_0000};
    tab[11] = '{1, 15, 64'h0000_0000_0000_0040};

    cyc = 0; go = 1'b0; inject_resp = 1'b0; rst = 1'b0;
    base[0] = 0; base[1] = 0; base[2] = 0; base[3] = 0;
    prep(0, 0, 5);
    repeat (3) step();
    chk("reset_en", ifa.dma_wr_en, 0);
    chk("reset_addr", ifa.dma_wr_addr, 0);
    chk("reset_data_nonzero", (ifa.dma_wr_data != '0), 0);
    chk("reset_done", done_a, 0);
    chk("reset_cv", cv_a, 0);
    rst = 1'b1;
    step();

    // Basic run
    base[0] = 64'h1000; base[1] = 64'h2000; base[2] = 64'h3000; base[3] = 64'h4000;
    run("basic", 0, SL_A, 0, 5, 1'b0);
    check_tab(0);

    // Over-completion in DONE, then restart from DONE
    inject_resp = 1'b1;
    step();
    inject_resp = 1'b0;
    step();
    chk("overcomplete_cv", s_cv, 65);
    chk("overcomplete_done", s_done, 1);
    base[0] = 64'h1_0000_0000; base[1] = 64'h1_0000_8000;
    base[2] = 64'h7000;        base[3] = 64'h40;
    prep(0, 0, 3);
    go = 1'b1;
    step();
    go = 1'b0;
    chk("restart_done_cleared", s_done, 0);
    chk("restart_cv_cleared", s_cv, 0);
    run("restart", 0, SL_A, 0, 3, 1'b0);

    // Backpressure: alternating full plus a long burst
    base[0] = 64'h8000; base[1] = 64'h9000; base[2] = 64'hA000; base[3] = 64'hB000;
    run("backpressure", 0, SL_A, 1, 5, 1'b0);

    // Responses coincide with issues; a second go during WRITE
    base[0] = 64'h10_0000; base[1] = 64'h20_0000; base[2] = 64'h30_0000; base[3] = 64'h40_0000;
    run("overlap", 0, SL_A, 0, 1, 1'b1);

    // Reset mid-run, stale responses in IDLE, then a fresh run
    base[0] = 64'h5000; base[1] = 64'h6000; base[2] = 64'h7000; base[3] = 64'h8000;
    prep(0, 0, 5);
    go = 1'b1;
    step();
    go = 1'b0;
    for (int n = 0; n < 200 && cap_q.size() < 10; n++) step();
    rst = 1'b0;
    #1;
    chk("midreset_en", ifa.dma_wr_en, 0);
    chk("midreset_addr", ifa.dma_wr_addr, 0);
    chk("midreset_data_nonzero", (ifa.dma_wr_data != '0), 0);
    chk("midreset_done", done_a, 0);
    chk("midreset_cv", cv_a, 0);
    due_q.delete();
    step();
    step();
    rst = 1'b1;
    inject_resp = 1'b1;
    step();
    step();
    inject_resp = 1'b0;
    step();
    chk("idle_stale_resp_cv", s_cv, 0);
    chk("idle_no_request", cap_q.size(), 10);
    base[0] = 64'hC000; base[1] = 64'hD000; base[2] = 64'hE000; base[3] = 64'hF000;
    run("after_reset", 0, SL_A, 0, 5, 1'b0);

    // Randomized runs against the reference address model
    for (int t = 0; t < 3; t++) begin
      for (int s = 0; s < 4; s++) base[s] = {$urandom, $urandom} & ~64'h3F;
      run("random", 0, SL_A, 2, $urandom_range(1, 8), 1'b0);
    end

    // Address wrap on the short-segment instance
    base[0] = 64'h100; base[1] = 64'h200; base[2] = 64'h300; base[3] = 64'hFFFF_FFFF_FFFF_FF80;
    run("wrap", 1, SL_B, 0, 2, 1'b0);
    check_tab(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
